tpg_timing_ctrl: RTL
====================

// Module: tpg_timing_ctrl
// PURPOSE
//  Configures and sequences the tpg video test pattern generator.
//  - Software writes the ten tpg timing fields into a shadow bank.
//  - A commit request copies the shadow bank to the active timing outputs, but
//    only at a frame boundary (rising edge of tpg vs_q). The tpg is held in
//    reset for SETTLE cycles during the copy.
//  - A watchdog forces the switch if no vs edge arrives in time.
//  - The block sits between the config bus and the tpg timing/reset inputs.
// PARAMETERS
//  H_BITS        12  width of horizontal timing fields (and tV_END, matching tpg)
//  V_BITS        12  width of vertical timing fields
//  SETTLE         4  cycles tpg_rst_n is held low after a load (>=1)
//  TIMEOUT_BITS  24  watchdog width; timeout after 2**TIMEOUT_BITS-1 cycles in WAIT_VS
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  cfg_we       in   1       shadow write strobe
//  cfg_addr     in   4       field index 0..9: HS_START,HS_END,HACT_START,HACT_END,H_END,
//                            VS_START,VS_END,VACT_START,VACT_END,V_END
//  cfg_wdata    in   16      write data, LSBs used (H_BITS or V_BITS)
//  commit_req   in   1       single-cycle commit pulse
//  commit_ack   out  1       one-cycle pulse when the new timing is live
//  cfg_err      out  1       one-cycle pulse, commit rejected
//  timeout_err  out  1       sticky, watchdog forced a switch
//  busy         out  1       commit in progress (state not HALT/RUN)
//  vs_q         in   1       vertical sync from tpg
//  tpg_rst_n    out  1       reset to tpg (active low), registered
//  tHS_START..tVACT_END  out  H_BITS/V_BITS  active timing fields to tpg
//  tV_END       out  H_BITS  active vertical end (tpg port width)
// BEHAVIOUR
//  Reset values:
//  - All shadow and active fields = 0; tpg_rst_n = 0.
//  - commit_ack, cfg_err, timeout_err, busy = 0; vs_d = 0; state = HALT.
//  Shadow writes:
//  - cfg_we writes shadow[cfg_addr] on the next edge, in any state.
//  - cfg_addr >= 10 is ignored, with no error.
//  Frame edge:
//  - vs_rise = vs_q & ~vs_d, where vs_d is vs_q registered.
//  Commit validation:
//  - A commit is rejected if shadow H_END == 0 or shadow V_END == 0.
//  - A rejected commit pulses cfg_err the next cycle; state is unchanged.
//  - commit_req while busy = 1 is ignored: no error, no queueing.
//  FSM:
//  - HALT: tpg_rst_n = 0. Valid commit_req -> LOAD.
//  - RUN: tpg_rst_n = 1. Valid commit_req -> WAIT_VS; watchdog cleared; timeout_err cleared.
//  - WAIT_VS: watchdog increments each cycle.
//    - vs_rise -> LOAD.
//    - Watchdog all-ones -> set timeout_err, then LOAD.
//    - vs_rise wins if both occur in the same cycle; timeout_err stays 0.
//  - LOAD: one cycle. Active fields <= shadow as sampled at the start of the cycle;
//    a same-cycle cfg_we lands in shadow only. tpg_rst_n <= 0. Settle counter = SETTLE-1.
//  - SETTLE: tpg_rst_n = 0; counter decrements. At 0 -> RUN; commit_ack pulses on RUN entry.
//  Timing:
//  - busy = 1 in WAIT_VS, LOAD and SETTLE.
//  - Active outputs change only in LOAD and are stable otherwise.
//  - From HALT, latency from commit_req to commit_ack = 2 + SETTLE cycles.
//  - tpg_rst_n rises in the same cycle commit_ack is high.
//  rst_n assertion mid-commit: immediate return to HALT, all values as at reset; no ack.
// TESTING
//  1. Reset, write a 640x480-style set (H_END=799, V_END=524), pulse commit_req in HALT
//     -> outputs update 1 cycle later, commit_ack at cycle 6 (SETTLE=4), tpg_rst_n=1 from there.
//  2. In RUN, write new H_END=857 and commit -> outputs hold old values until the cycle
//     after vs_q rises, then tpg_rst_n low 4 cycles, then ack.
//  3. Commit with shadow V_END=0 -> cfg_err pulse, state and outputs unchanged, no ack.
//  4. Commit in RUN with vs_q tied 0, TIMEOUT_BITS=4 -> switch after 15 cycles, timeout_err=1;
//     the next commit clears it.
//  5. Second commit_req and cfg_we during WAIT_VS/LOAD -> req ignored; write to the LOAD cycle
//     not applied until the following commit.
//  6. rst_n asserted during SETTLE -> tpg_rst_n=0, all outputs 0, HALT, no commit_ack.

Source files
------------

// File: rtl/tpg_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tpg_timing_ctrl
//  Description : Shadow/active timing register bank for the tpg pattern
//                generator. A commit swaps the shadow bank into the active
//                outputs at a frame boundary (vs rising edge), holding the
//                tpg in reset while it settles. A watchdog forces the swap
//                if no frame edge turns up.
//  Revision    : 1.0  initial release
// ============================================================================
module tpg_timing_ctrl #(
  parameter int H_BITS       = 12,
  parameter int V_BITS       = 12,
  parameter int SETTLE       = 4,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              commit_req,
  output logic              commit_ack,
  output logic              cfg_err,
  output logic              timeout_err,
  output logic              busy,
  input  logic              vs_q,
  output logic              tpg_rst_n,
  output logic [H_BITS-1:0] tHS_START,
  output logic [H_BITS-1:0] tHS_END,
  output logic [H_BITS-1:0] tHACT_START,
  output logic [H_BITS-1:0] tHACT_END,
  output logic [H_BITS-1:0] tH_END,
  output logic [V_BITS-1:0] tVS_START,
  output logic [V_BITS-1:0] tVS_END,
  output logic [V_BITS-1:0] tVACT_START,
  output logic [V_BITS-1:0] tVACT_END,
  output logic [H_BITS-1:0] tV_END
);

  // Storage width covers the widest field; tV_END follows the tpg's H width.
  localparam int c_FW      = (H_BITS > V_BITS) ? H_BITS : V_BITS;
  localparam int c_NF      = 10;
  localparam int c_SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int c_IDX_HE  = 4;
  localparam int c_IDX_VE  = 9;

  localparam logic [2:0] c_HALT    = 3'd0;
  localparam logic [2:0] c_RUN     = 3'd1;
  localparam logic [2:0] c_WAIT_VS = 3'd2;
  localparam logic [2:0] c_LOAD    = 3'd3;
  localparam logic [2:0] c_SETTLE  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [c_FW-1:0]         sh_q  [c_NF];
  logic [c_FW-1:0]         act_q [c_NF];
  logic                    vs_dly_q;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic [c_SW-1:0]         cnt_q;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;
  logic                    trst_q, trst_d;

  logic w_vs_rise;
  logic w_commit_ok;
  logic w_wd_full;
  logic w_start;
  logic unused_wdata;

  assign w_vs_rise   = vs_q & ~vs_dly_q;
  assign w_commit_ok = (sh_q[c_IDX_HE][H_BITS-1:0] != '0) &&
                       (sh_q[c_IDX_VE][H_BITS-1:0] != '0);
  assign w_wd_full   = &wd_q;
  // Accepted commit out of RUN: restarts the watchdog and clears timeout_err.
  assign w_start     = (state_q == c_RUN) && commit_req && w_commit_ok;
  assign unused_wdata = &{1'b0, cfg_wdata[15:c_FW]};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_HALT;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_HALT:    if (commit_req && w_commit_ok) state_d = c_LOAD;
      c_RUN:     if (commit_req && w_commit_ok) state_d = c_WAIT_VS;
      c_WAIT_VS: if (w_vs_rise || w_wd_full)    state_d = c_LOAD;
      c_LOAD:    state_d = c_SETTLE;
      c_SETTLE:  if (cnt_q == '0)               state_d = c_RUN;
      default:   state_d = c_HALT;
    endcase
  end

  // FSM outputs: busy decode plus next values of the registered strobes
  always_comb begin
    busy   = (state_q == c_WAIT_VS) || (state_q == c_LOAD) || (state_q == c_SETTLE);
    ack_d  = (state_q == c_SETTLE) && (cnt_q == '0);
    err_d  = commit_req && !busy && !w_commit_ok;
    tmo_d  = tmo_q;
    if (w_start) tmo_d = 1'b0;
    // A coincident frame edge wins over the watchdog and leaves the flag clear.
    if ((state_q == c_WAIT_VS) && w_wd_full && !w_vs_rise) tmo_d = 1'b1;
    // tpg keeps running through WAIT_VS and the LOAD cycle, then sits in reset.
    case (state_q)
      c_RUN, c_WAIT_VS: trst_d = 1'b1;
      c_SETTLE:         trst_d = (cnt_q == '0);
      default:          trst_d = 1'b0;
    endcase
  end

  // Registered status/strobe outputs and frame-edge delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      trst_q   <= 1'b0;
      vs_dly_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      trst_q   <= trst_d;
      vs_dly_q <= vs_q;
    end
  end

  // Watchdog counts WAIT_VS cycles; settle counter runs down through SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_start)                     wd_q <= '0;
      else if (state_q == c_WAIT_VS)   wd_q <= wd_q + TIMEOUT_BITS'(1);
      if (state_q == c_LOAD)           cnt_q <= c_SW'(SETTLE - 1);
      else if (state_q == c_SETTLE)    cnt_q <= cnt_q - c_SW'(1);
    end
  end

  // Shadow bank writes (any state) and active bank load (LOAD only)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NF; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      if (cfg_we && (cfg_addr < 4'd10)) sh_q[cfg_addr] <= cfg_wdata[c_FW-1:0];
      // Right-hand side is the pre-edge shadow, so a same-cycle write is excluded.
      if (state_q == c_LOAD) begin
        for (int i = 0; i < c_NF; i++) act_q[i] <= sh_q[i];
      end
    end
  end

  assign commit_ack  = ack_q;
  assign cfg_err     = err_q;
  assign timeout_err = tmo_q;
  assign tpg_rst_n   = trst_q;

  assign tHS_START   = act_q[0][H_BITS-1:0];
  assign tHS_END     = act_q[1][H_BITS-1:0];
  assign tHACT_START = act_q[2][H_BITS-1:0];
  assign tHACT_END   = act_q[3][H_BITS-1:0];
  assign tH_END      = act_q[4][H_BITS-1:0];
  assign tVS_START   = act_q[5][V_BITS-1:0];
  assign tVS_END     = act_q[6][V_BITS-1:0];
  assign tVACT_START = act_q[7][V_BITS-1:0];
  assign tVACT_END   = act_q[8][V_BITS-1:0];
  assign tV_END      = act_q[9][H_BITS-1:0];

endmodule
`default_nettype wire
